convertidor_binario_bcd_secuencial: RTL and testbench

Parametrised, sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock, with a start/done handshake. Successor to the combinational 4-digit converter: generic input width and digit count, registered outputs, overflow saturation, and a leading-zero blanking mask. Sits between binary counters/ALU results and the 7-segment multiplexed display driver.

---
 rtl/convertidor_binario_bcd_secuencial.sv | 127 ++++++++++++
 tb/tb_convertidor_binario_bcd_secuencial.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/convertidor_binario_bcd_secuencial.sv
// rtl/convertidor_binario_bcd_secuencial.sv - sequential double-dabble binary-to-BCD converter
// One input bit per clock; results and blank mask are registered and held until the next FIN.
module convertidor_binario_bcd_secuencial #(
  parameter int ANCHO   = 10,
  parameter int DIGITOS = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   inicio,
  input  logic [ANCHO-1:0]       dato,
  output logic                   ocupado,
  output logic                   listo,
  output logic [4*DIGITOS-1:0]   bcd,
  output logic                   desborde,
  output logic [DIGITOS-1:0]     apagar
);

  localparam int CW = $clog2(ANCHO + 1);

  localparam logic [1:0] REPOSO   = 2'd0;
  localparam logic [1:0] DESPLAZA = 2'd1;
  localparam logic [1:0] FIN      = 2'd2;

  logic [1:0]           estado_q, estado_d;
  logic [ANCHO-1:0]     bin_q, bin_d;
  logic [4*DIGITOS-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 listo_q, listo_d;
  logic [4*DIGITOS-1:0] bcd_q, bcd_d;
  logic                 desborde_q, desborde_d;
  logic [DIGITOS-1:0]   apagar_q, apagar_d;

  logic [4*DIGITOS-1:0] ajustado;
  logic [DIGITOS-1:0]   mascara;
  logic                 cero_sup;

  // Add-3 correction on every digit in parallel, ahead of the shift.
  always_comb begin
    ajustado = acc_q;
    for (int i = 0; i < DIGITOS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        ajustado[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Digit i is blanked when it and every digit above it are zero; units never blank.
  always_comb begin
    mascara  = '0;
    cero_sup = 1'b1;
    for (int i = DIGITOS - 1; i >= 1; i--) begin
      cero_sup   = cero_sup & (acc_q[4*i +: 4] == 4'd0);
      mascara[i] = cero_sup;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    bin_d      = bin_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    listo_d    = 1'b0;
    bcd_d      = bcd_q;
    desborde_d = desborde_q;
    apagar_d   = apagar_q;
    case (estado_q)
      REPOSO: begin
        if (inicio) begin
          bin_d    = dato;
          acc_d    = '0;
          ovf_d    = 1'b0;
          cnt_d    = CW'(ANCHO);
          estado_d = DESPLAZA;
        end
      end
      DESPLAZA: begin
        {acc_d, bin_d} = {ajustado[4*DIGITOS-2:0], bin_q, 1'b0};
        ovf_d          = ovf_q | ajustado[4*DIGITOS-1];
        cnt_d          = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          estado_d = FIN;
        end
      end
      FIN: begin
        listo_d    = 1'b1;
        desborde_d = ovf_q;
        bcd_d      = ovf_q ? {DIGITOS{4'h9}} : acc_q;
        apagar_d   = ovf_q ? '0 : mascara;
        estado_d   = REPOSO;
      end
      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q   <= REPOSO;
      bin_q      <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      listo_q    <= 1'b0;
      bcd_q      <= '0;
      desborde_q <= 1'b0;
      apagar_q   <= '0;
    end else begin
      estado_q   <= estado_d;
      bin_q      <= bin_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      listo_q    <= listo_d;
      bcd_q      <= bcd_d;
      desborde_q <= desborde_d;
      apagar_q   <= apagar_d;
    end
  end

  assign ocupado  = (estado_q == DESPLAZA);
  assign listo    = listo_q;
  assign bcd      = bcd_q;
  assign desborde = desborde_q;
  assign apagar   = apagar_q;

endmodule

// File: tb/tb_convertidor_binario_bcd_secuencial.sv
// tb/tb_convertidor_binario_bcd_secuencial.sv - scoreboard bench, 4-digit and 3-digit instances
// Both instances share stimulus; each has its own expected-result queue.
module tb_convertidor_binario_bcd_secuencial;

  logic        clk;
  logic        reset_n;
  logic        inicio;
  logic [9:0]  dato;

  logic        ocupado4, listo4, desborde4;
  logic [15:0] bcd4;
  logic [3:0]  apagar4;
  logic        ocupado3, listo3, desborde3;
  logic [11:0] bcd3;
  logic [2:0]  apagar3;

  typedef struct packed {
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  ap;
  } res_t;

  res_t q4[$];
  res_t q3[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  convertidor_binario_bcd_secuencial #(.ANCHO(10), .DIGITOS(4)) u_d4 (
    .clk(clk), .reset_n(reset_n), .inicio(inicio), .dato(dato),
    .ocupado(ocupado4), .listo(listo4), .bcd(bcd4), .desborde(desborde4), .apagar(apagar4)
  );

  convertidor_binario_bcd_secuencial #(.ANCHO(10), .DIGITOS(3)) u_d3 (
    .clk(clk), .reset_n(reset_n), .inicio(inicio), .dato(dato),
    .ocupado(ocupado3), .listo(listo3), .bcd(bcd3), .desborde(desborde3), .apagar(apagar3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t modelo(input int v, input int d);
    res_t r;
    int   lim;
    int   t;
    int   pot;
    r   = '0;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    if (v >= lim) begin
      for (int i = 0; i < d; i++) r.bcd[4*i +: 4] = 4'h9;
      r.ovf = 1'b1;
    end else begin
      t = v;
      for (int i = 0; i < d; i++) begin
        r.bcd[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
      pot = 1;
      for (int i = 1; i < d; i++) begin
        pot     = pot * 10;
        r.ap[i] = (v < pot);
      end
    end
    return r;
  endfunction

  task automatic push_expect(input int v);
    q4.push_back(modelo(v, 4));
    q3.push_back(modelo(v, 3));
  endtask

  always @(negedge clk) begin
    res_t e;
    if (listo4) begin
      n_cmp++;
      if (q4.size() == 0) begin
        n_bad++;
        $display("FAIL d4_unexpected_listo: got bcd=%h, required no listo", bcd4);
      end else begin
        e = q4.pop_front();
        if ({bcd4, desborde4, apagar4} !== {e.bcd, e.ovf, e.ap}) begin
          n_bad++;
          $display("FAIL d4_result: got bcd=%h ovf=%b ap=%b, required bcd=%h ovf=%b ap=%b",
                   bcd4, desborde4, apagar4, e.bcd, e.ovf, e.ap);
        end
      end
    end
    if (listo3) begin
      n_cmp++;
      if (q3.size() == 0) begin
        n_bad++;
        $display("FAIL d3_unexpected_listo: got bcd=%h, required no listo", bcd3);
      end else begin
        e = q3.pop_front();
        if ({bcd3, desborde3, apagar3} !== {e.bcd[11:0], e.ovf, e.ap[2:0]}) begin
          n_bad++;
          $display("FAIL d3_result: got bcd=%h ovf=%b ap=%b, required bcd=%h ovf=%b ap=%b",
                   bcd3, desborde3, apagar3, e.bcd[11:0], e.ovf, e.ap[2:0]);
        end
      end
    end
  end

  task automatic start_conv(input int v, input bit esperar);
    @(negedge clk);
    dato   = 10'(v);
    inicio = 1'b1;
    if (esperar) push_expect(v);
    @(negedge clk);
    inicio = 1'b0;
  endtask

  task automatic wait_empty(input string nombre);
    int ciclos;
    ciclos = 0;
    while ((q4.size() != 0 || q3.size() != 0) && ciclos < 200) begin
      @(negedge clk);
      ciclos++;
    end
    if (ciclos >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d pending, required 0", nombre, q4.size() + q3.size());
      q4.delete();
      q3.delete();
    end
  endtask

  task automatic check_zero(input string nombre);
    n_cmp++;
    if ({ocupado4, listo4, bcd4, desborde4, apagar4} !== 23'd0) begin
      n_bad++;
      $display("FAIL %s_d4: got oc=%b li=%b bcd=%h ov=%b ap=%b, required all zero",
               nombre, ocupado4, listo4, bcd4, desborde4, apagar4);
    end
    n_cmp++;
    if ({ocupado3, listo3, bcd3, desborde3, apagar3} !== 18'd0) begin
      n_bad++;
      $display("FAIL %s_d3: got oc=%b li=%b bcd=%h ov=%b ap=%b, required all zero",
               nombre, ocupado3, listo3, bcd3, desborde3, apagar3);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    inicio  = 1'b0;
    dato    = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency();
    int oc_cnt;
    int j;
    start_conv(1023, 1'b1);
    oc_cnt = 0;
    j      = 0;
    while (!listo4 && j < 40) begin
      if (ocupado4) oc_cnt++;
      @(negedge clk);
      j++;
    end
    n_cmp++;
    if (oc_cnt != 10) begin
      n_bad++;
      $display("FAIL latency_ocupado: got %0d cycles, required 10", oc_cnt);
    end
    n_cmp++;
    if (j != 11) begin
      n_bad++;
      $display("FAIL latency_listo: got %0d cycles, required 11", j);
    end
    n_cmp++;
    if (ocupado4 !== 1'b0) begin
      n_bad++;
      $display("FAIL latency_ocupado_at_listo: got %b, required 0", ocupado4);
    end
    wait_empty("latency");
  endtask

  task automatic test_values();
    int vals[6] = '{0, 7, 40, 999, 1000, 1023};
    foreach (vals[i]) begin
      start_conv(vals[i], 1'b1);
      wait_empty("values");
    end
  endtask

  task automatic test_ignore();
    int pulsos;
    start_conv(123, 1'b1);
    repeat (2) @(negedge clk);
    dato   = 10'd456;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    pulsos = 0;
    for (int i = 0; i < 30; i++) begin
      if (listo4) pulsos++;
      @(negedge clk);
    end
    n_cmp++;
    if (pulsos != 1) begin
      n_bad++;
      $display("FAIL ignore_listo_count: got %0d, required 1", pulsos);
    end
    wait_empty("ignore");
  endtask

  task automatic test_back_to_back();
    int ult;
    int vistos;
    int ciclo;
    @(negedge clk);
    dato = 10'd321;
    for (int i = 0; i < 3; i++) push_expect(321);
    inicio = 1'b1;
    ult    = -1;
    vistos = 0;
    ciclo  = 0;
    while (vistos < 3 && ciclo < 100) begin
      @(negedge clk);
      ciclo++;
      if (listo4) begin
        if (ult >= 0) begin
          n_cmp++;
          if (ciclo - ult != 12) begin
            n_bad++;
            $display("FAIL b2b_interval: got %0d, required 12", ciclo - ult);
          end
        end
        ult = ciclo;
        vistos++;
      end
    end
    inicio = 1'b0;
    wait_empty("b2b");
  endtask

  task automatic test_abort();
    int pulsos;
    start_conv(500, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_zero("abort");
    reset_n = 1'b1;
    pulsos  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (listo4 || listo3) pulsos++;
    end
    n_cmp++;
    if (pulsos != 0) begin
      n_bad++;
      $display("FAIL abort_listo: got %0d pulses, required 0", pulsos);
    end
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 1024; v++) begin
      start_conv(v, 1'b1);
      wait_empty("sweep");
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_values();
    test_ignore();
    test_back_to_back();
    test_abort();
    test_sweep();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
